audio_adc_rx_stream: RTL and testbench

Parametrised serial audio ADC receiver that replaces the fixed audio-input path. It samples the codec's BCLK, ADCLRCK and ADCDAT in the system clock domain and deserialises I2S or left-justified frames of configurable width. Mono or stereo samples are buffered in an internal FIFO and presented on a valid/ready stream for the processor/DSP side.

---
 rtl/audio_adc_rx_stream.sv | 161 ++++++++++++++++
 tb/tb_audio_adc_rx_stream.sv | 257 +++++++++++++++++++++++++
 2 files changed

// File: rtl/audio_adc_rx_stream.sv
// Serial audio ADC receiver: synchronises codec BCLK/ADCLRCK/ADCDAT, deserialises
// I2S or left-justified frames and queues samples in a FWFT FIFO on a valid/ready stream.
module audio_adc_rx_stream #(
  parameter int SAMPLE_WIDTH = 24,
  parameter int NUM_CHANNELS = 2,
  parameter int FIFO_DEPTH   = 8,
  parameter int LEVEL_W      = 4
) (
  input  logic                    clk_clk,
  input  logic                    reset_reset_n,
  input  logic                    audio_interface_ADCDAT,
  input  logic                    audio_interface_ADCLRCK,
  input  logic                    audio_interface_BCLK,
  input  logic                    enable,
  input  logic                    i2s_mode,
  input  logic                    clear_overflow,
  output logic [SAMPLE_WIDTH-1:0] out_data,
  output logic                    out_channel,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic [LEVEL_W-1:0]      fifo_level,
  output logic                    overflow
);

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam logic [SAMPLE_WIDTH-1:0] FIRST_BIT = {1'b1, {(SAMPLE_WIDTH-1){1'b0}}};

  typedef enum logic [2:0] {S_IDLE, S_SKIP, S_SHIFT, S_PUSH, S_WAIT} state_t;

  logic [2:0] bclk_sr;
  logic [2:0] lrck_sr;
  logic [1:0] dat_sr;
  logic       bclk_rise;
  logic       lrck_toggle;

  // Synchronisers keep tracking the pins through reset so no false LRCK edge appears on release.
  always_ff @(posedge clk_clk) begin
    bclk_sr <= {bclk_sr[1:0], audio_interface_BCLK};
    lrck_sr <= {lrck_sr[1:0], audio_interface_ADCLRCK};
    dat_sr  <= {dat_sr[0], audio_interface_ADCDAT};
  end

  assign bclk_rise   = bclk_sr[1] & ~bclk_sr[2];
  assign lrck_toggle = lrck_sr[1] ^ lrck_sr[2];

  state_t                  state, state_n;
  logic [SAMPLE_WIDTH-1:0] shift_reg, shift_n;
  logic [SAMPLE_WIDTH-1:0] bit_mask, mask_n;
  logic                    channel, chan_n;
  logic                    wr_req;
  logic                    start;

  always_ff @(posedge clk_clk) begin
    if (!reset_reset_n) begin
      state     <= S_IDLE;
      shift_reg <= '0;
      bit_mask  <= '0;
      channel   <= 1'b0;
    end else begin
      state     <= state_n;
      shift_reg <= shift_n;
      bit_mask  <= mask_n;
      channel   <= chan_n;
    end
  end

  // bit_mask walks a one-hot from the MSB, so a short frame is already left-aligned and zero-filled.
  always_comb begin
    state_n = state;
    shift_n = shift_reg;
    mask_n  = bit_mask;
    chan_n  = channel;
    wr_req  = 1'b0;
    start   = 1'b0;
    if (!enable) begin
      state_n = S_IDLE;
    end else begin
      case (state)
        S_IDLE:  start = lrck_toggle;
        S_SKIP: begin
          if (lrck_toggle)    start = 1'b1;
          else if (bclk_rise) state_n = S_SHIFT;
        end
        S_SHIFT: begin
          if (lrck_toggle) begin
            wr_req = 1'b1;
            start  = 1'b1;
          end else if (bclk_rise) begin
            shift_n = dat_sr[1] ? (shift_reg | bit_mask) : shift_reg;
            mask_n  = bit_mask >> 1;
            if (bit_mask[0]) state_n = S_PUSH;
          end
        end
        S_PUSH: begin
          wr_req = 1'b1;
          if (lrck_toggle) start = 1'b1;
          else             state_n = S_WAIT;
        end
        S_WAIT:  start = lrck_toggle;
        default: state_n = S_IDLE;
      endcase
      if (start) begin
        chan_n  = i2s_mode ? lrck_sr[1] : ~lrck_sr[1];
        shift_n = '0;
        mask_n  = FIRST_BIT;
        state_n = i2s_mode ? S_SKIP : S_SHIFT;
      end
    end
  end

  logic                    fifo_wr;
  logic                    do_push;
  logic                    do_pop;
  logic                    full;
  logic [AW-1:0]           wr_ptr;
  logic [AW-1:0]           rd_ptr;
  logic [LEVEL_W-1:0]      level_n;
  logic [SAMPLE_WIDTH-1:0] mem_data [FIFO_DEPTH];
  logic                    mem_chan [FIFO_DEPTH];

  assign fifo_wr = wr_req && ((NUM_CHANNELS != 1) || !channel);
  assign full    = (fifo_level == LEVEL_W'(FIFO_DEPTH));
  assign do_pop  = out_valid & out_ready;
  assign do_push = fifo_wr & (~full | do_pop);

  always_comb begin
    level_n = fifo_level;
    if (do_push && !do_pop)      level_n = fifo_level + 1'b1;
    else if (!do_push && do_pop) level_n = fifo_level - 1'b1;
  end

  // A push into a full FIFO lands in the slot the simultaneous pop is vacating.
  always_ff @(posedge clk_clk) begin
    if (!reset_reset_n) begin
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      fifo_level <= '0;
      out_valid  <= 1'b0;
      overflow   <= 1'b0;
      for (int i = 0; i < FIFO_DEPTH; i++) begin
        mem_data[i] <= '0;
        mem_chan[i] <= 1'b0;
      end
    end else begin
      if (do_push) begin
        mem_data[wr_ptr] <= shift_reg;
        mem_chan[wr_ptr] <= channel;
        wr_ptr           <= wr_ptr + 1'b1;
      end
      if (do_pop) rd_ptr <= rd_ptr + 1'b1;
      fifo_level <= level_n;
      out_valid  <= (level_n != '0);
      if (fifo_wr && full && !do_pop) overflow <= 1'b1;
      else if (clear_overflow)        overflow <= 1'b0;
    end
  end

  assign out_data    = mem_data[rd_ptr];
  assign out_channel = mem_chan[rd_ptr];

endmodule

// File: tb/tb_audio_adc_rx_stream.sv
// Directed bench for audio_adc_rx_stream: table-driven frames plus hand-written
// sequences for short frames, mono filtering, overflow, enable drop and reset.
module tb_audio_adc_rx_stream;

  logic        clk = 1'b0;
  logic        reset_n;
  logic        adc_dat, adc_lrck, adc_bclk;
  logic        enable, en_mono, i2s_mode, clear_overflow, out_ready;
  logic        mono_ready;
  logic [23:0] out_data, mono_data;
  logic        out_channel, mono_channel;
  logic        out_valid, mono_valid;
  logic [3:0]  fifo_level, mono_level;
  logic        overflow, mono_overflow;

  int          check_cnt = 0;
  int          pass_cnt  = 0;
  logic [24:0] got_q[$];
  logic [24:0] mono_q[$];
  int          mono_max_level = 0;

  typedef struct {
    logic        i2s;
    logic        lrck;
    logic [23:0] data;
    logic [23:0] exp_data;
    logic        exp_chan;
  } vec_t;

  vec_t vecs[7];

  always #5 clk = ~clk;

  audio_adc_rx_stream dut (
    .clk_clk                 (clk),
    .reset_reset_n           (reset_n),
    .audio_interface_ADCDAT  (adc_dat),
    .audio_interface_ADCLRCK (adc_lrck),
    .audio_interface_BCLK    (adc_bclk),
    .enable                  (enable),
    .i2s_mode                (i2s_mode),
    .clear_overflow          (clear_overflow),
    .out_data                (out_data),
    .out_channel             (out_channel),
    .out_valid               (out_valid),
    .out_ready               (out_ready),
    .fifo_level              (fifo_level),
    .overflow                (overflow)
  );

  audio_adc_rx_stream #(.NUM_CHANNELS(1)) dut_mono (
    .clk_clk                 (clk),
    .reset_reset_n           (reset_n),
    .audio_interface_ADCDAT  (adc_dat),
    .audio_interface_ADCLRCK (adc_lrck),
    .audio_interface_BCLK    (adc_bclk),
    .enable                  (en_mono),
    .i2s_mode                (i2s_mode),
    .clear_overflow          (clear_overflow),
    .out_data                (mono_data),
    .out_channel             (mono_channel),
    .out_valid               (mono_valid),
    .out_ready               (mono_ready),
    .fifo_level              (mono_level),
    .overflow                (mono_overflow)
  );

  // Inputs change at posedge+3, so the negedge sees exactly what the next posedge will act on.
  always @(negedge clk) begin
    if (reset_n && out_valid && out_ready) got_q.push_back({out_channel, out_data});
    if (reset_n && mono_valid && mono_ready) mono_q.push_back({mono_channel, mono_data});
    if (int'(mono_level) > mono_max_level) mono_max_level = int'(mono_level);
  end

  task automatic waitClks(input int n);
    repeat (n) @(posedge clk);
    #3;
  endtask

  task automatic sendBit(input logic b);
    adc_bclk = 1'b0;
    adc_dat  = b;
    waitClks(4);
    adc_bclk = 1'b1;
    waitClks(4);
  endtask

  task automatic applyStimulus(input logic i2s, input logic lrck, input logic [23:0] data,
                               input int nbits, input int slot);
    i2s_mode = i2s;
    for (int k = 0; k < slot; k++) begin
      int   pos;
      logic b;
      pos = i2s ? k - 1 : k;
      b   = (pos >= 0 && pos < nbits) ? data[nbits-1-pos] : 1'b0;
      if (k == 0) adc_lrck = lrck;
      sendBit(b);
    end
  endtask

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    check_cnt++;
    if (actual === expected) pass_cnt++;
    else $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, actual, expected);
  endtask

  task automatic checkEntry(input string name, input logic [23:0] exp_data, input logic exp_chan);
    logic [24:0] e;
    if (got_q.size() == 0) begin
      check_cnt++;
      $display("[TB] FAIL %s: got no sample, expected 0x%0h ch%0d", name, exp_data, exp_chan);
    end else begin
      e = got_q.pop_front();
      checkOutput({name, " data"}, 32'(e[23:0]), 32'(exp_data));
      checkOutput({name, " chan"}, 32'(e[24]), 32'(exp_chan));
    end
  endtask

  task automatic checkMono(input string name, input logic [23:0] exp_data);
    logic [24:0] e;
    if (mono_q.size() == 0) begin
      check_cnt++;
      $display("[TB] FAIL %s: got no sample, expected 0x%0h", name, exp_data);
    end else begin
      e = mono_q.pop_front();
      checkOutput({name, " data"}, 32'(e[23:0]), 32'(exp_data));
      checkOutput({name, " chan"}, 32'(e[24]), 32'd0);
    end
  endtask

  task automatic checkResetState(input string tag);
    checkOutput({tag, " out_valid"},   32'(out_valid),   32'd0);
    checkOutput({tag, " out_data"},    32'(out_data),    32'd0);
    checkOutput({tag, " out_channel"}, 32'(out_channel), 32'd0);
    checkOutput({tag, " fifo_level"},  32'(fifo_level),  32'd0);
    checkOutput({tag, " overflow"},    32'(overflow),    32'd0);
  endtask

  initial begin
    // I2S: LRCK low = left; left-justified: LRCK high = left.
    vecs[0] = '{1'b1, 1'b0, 24'h123456, 24'h123456, 1'b0};
    vecs[1] = '{1'b1, 1'b1, 24'hABCDEF, 24'hABCDEF, 1'b1};
    vecs[2] = '{1'b0, 1'b0, 24'h5A5A5A, 24'h5A5A5A, 1'b1};
    vecs[3] = '{1'b0, 1'b1, 24'h800001, 24'h800001, 1'b0};
    vecs[4] = '{1'b0, 1'b0, 24'h000001, 24'h000001, 1'b1};
    vecs[5] = '{1'b1, 1'b1, 24'hFFFFFF, 24'hFFFFFF, 1'b1};
    vecs[6] = '{1'b1, 1'b0, 24'h7FFFFE, 24'h7FFFFE, 1'b0};

    reset_n        = 1'b0;
    adc_dat        = 1'b0;
    adc_lrck       = 1'b1;
    adc_bclk       = 1'b0;
    enable         = 1'b1;
    en_mono        = 1'b0;
    i2s_mode       = 1'b1;
    clear_overflow = 1'b0;
    out_ready      = 1'b1;
    mono_ready     = 1'b1;
    waitClks(6);
    reset_n = 1'b1;
    waitClks(2);
    checkResetState("reset");

    for (int i = 0; i < 7; i++) begin
      got_q.delete();
      applyStimulus(vecs[i].i2s, vecs[i].lrck, vecs[i].data, 24, 32);
      waitClks(10);
      checkOutput($sformatf("vec%0d count", i), 32'(got_q.size()), 32'd1);
      checkEntry($sformatf("vec%0d", i), vecs[i].exp_data, vecs[i].exp_chan);
    end
    checkOutput("stereo overflow", 32'(overflow), 32'd0);

    // Short frame: LRCK toggles after 16 bits of ones.
    got_q.delete();
    applyStimulus(1'b1, 1'b1, 24'h00FFFF, 16, 17);
    applyStimulus(1'b1, 1'b0, 24'h13579B, 24, 32);
    waitClks(10);
    checkOutput("short count", 32'(got_q.size()), 32'd2);
    checkEntry("short frame", 24'hFFFF00, 1'b1);
    checkEntry("after short", 24'h13579B, 1'b0);

    // Mono instance: right frames are discarded.
    en_mono = 1'b1;
    waitClks(4);
    mono_q.delete();
    applyStimulus(1'b0, 1'b1, 24'h000011, 24, 32);
    applyStimulus(1'b0, 1'b0, 24'h000022, 24, 32);
    applyStimulus(1'b0, 1'b1, 24'h000033, 24, 32);
    waitClks(10);
    checkOutput("mono count", 32'(mono_q.size()), 32'd2);
    checkMono("mono first", 24'h000011);
    checkMono("mono second", 24'h000033);
    checkOutput("mono max level", 32'(mono_max_level), 32'd1);
    checkOutput("mono overflow", 32'(mono_overflow), 32'd0);
    en_mono = 1'b0;

    // Overflow: nine frames into an eight-deep FIFO with the consumer stalled.
    got_q.delete();
    out_ready = 1'b0;
    for (int i = 0; i < 8; i++)
      applyStimulus(1'b1, 1'(i % 2 == 1), 24'h100000 + 24'(i), 24, 32);
    waitClks(10);
    checkOutput("full level", 32'(fifo_level), 32'd8);
    checkOutput("full no overflow yet", 32'(overflow), 32'd0);
    applyStimulus(1'b1, 1'b0, 24'h100008, 24, 32);
    waitClks(10);
    checkOutput("overflow level", 32'(fifo_level), 32'd8);
    checkOutput("overflow set", 32'(overflow), 32'd1);
    clear_overflow = 1'b1;
    waitClks(1);
    clear_overflow = 1'b0;
    waitClks(2);
    checkOutput("overflow cleared", 32'(overflow), 32'd0);
    out_ready = 1'b1;
    waitClks(20);
    checkOutput("drain count", 32'(got_q.size()), 32'd8);
    for (int i = 0; i < 8; i++)
      checkEntry($sformatf("drain%0d", i), 24'h100000 + 24'(i), 1'(i % 2 == 1));
    checkOutput("drained level", 32'(fifo_level), 32'd0);

    // Enable dropped after 10 bits: nothing pushed, capture resumes on next LRCK edge.
    got_q.delete();
    applyStimulus(1'b1, 1'b1, 24'hFFFFFF, 24, 11);
    enable = 1'b0;
    waitClks(20);
    enable = 1'b1;
    for (int i = 0; i < 8; i++) sendBit(1'b1);
    checkOutput("enable drop no push", 32'(got_q.size()), 32'd0);
    checkOutput("enable drop level", 32'(fifo_level), 32'd0);
    applyStimulus(1'b1, 1'b0, 24'h2468AC, 24, 32);
    waitClks(10);
    checkOutput("resume count", 32'(got_q.size()), 32'd1);
    checkEntry("resume", 24'h2468AC, 1'b0);

    // Reset mid-frame with a stored sample.
    got_q.delete();
    out_ready = 1'b0;
    applyStimulus(1'b1, 1'b1, 24'h0F0F0F, 24, 32);
    waitClks(4);
    checkOutput("pre-reset level", 32'(fifo_level), 32'd1);
    applyStimulus(1'b1, 1'b0, 24'hFFFFFF, 24, 11);
    reset_n = 1'b0;
    waitClks(2);
    reset_n = 1'b1;
    waitClks(3);
    checkResetState("mid reset");
    out_ready = 1'b1;
    applyStimulus(1'b1, 1'b1, 24'h654321, 24, 32);
    waitClks(10);
    checkOutput("post reset count", 32'(got_q.size()), 32'd1);
    checkEntry("post reset", 24'h654321, 1'b1);

    $display("%0d/%0d checks passed", pass_cnt, check_cnt);
    $finish;
  end

endmodule
